// File: rtl/hazard_unit.sv
// hazard_unit: per-operand forwarding selects plus load-use / divider / jump
// interlock control, sequenced by a small FSM with a 3-bit cycle counter.
`default_nettype none

module hazard_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_SRC      = 2,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_raddr_i,
  input  logic [NUM_SRC-1:0]            id_re_i,
  input  logic [REG_ADDR_W-1:0]         ex_waddr_i,
  input  logic                          ex_we_i,
  input  logic                          ex_is_load_i,
  input  logic [REG_ADDR_W-1:0]         mem_waddr_i,
  input  logic                          mem_we_i,
  input  logic [REG_ADDR_W-1:0]         wb_waddr_i,
  input  logic                          wb_we_i,
  input  logic                          jump_i,
  input  logic                          div_busy_i,
  output logic [2*NUM_SRC-1:0]          fwd_sel_o,
  output logic                          hold_pc_o,
  output logic                          hold_if_id_o,
  output logic                          bubble_id_ex_o,
  output logic                          flush_o,
  output logic                          busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    DIV_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  // The first stall/flush cycle is issued from IDLE, so the counter only
  // covers the remaining cycles; a length of 1 never leaves IDLE.
  localparam logic [2:0] c_LD_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [2:0] c_FL_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam state_t     c_LD_NEXT   = (LOAD_LAT > 1)     ? LD_STALL : IDLE;
  localparam state_t     c_FL_NEXT   = (FLUSH_CYCLES > 1) ? FLUSH    : IDLE;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_cnt;
  logic [2:0]            w_cnt_nxt;
  logic [2*NUM_SRC-1:0]  w_fwd;
  logic [NUM_SRC-1:0]    w_lu_src;
  logic                  w_load_use;
  logic                  w_hold;
  logic                  w_flush;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_ADDR_W-1:0] w_addr;
    logic                  w_ok;
    logic                  w_ex;
    logic                  w_mem;
    logic                  w_wb;

    assign w_addr = id_raddr_i[k*REG_ADDR_W +: REG_ADDR_W];
    assign w_ok   = id_re_i[k] & (|w_addr);
    assign w_ex   = w_ok & ex_we_i  & (ex_waddr_i  == w_addr);
    assign w_mem  = w_ok & mem_we_i & (mem_waddr_i == w_addr);
    assign w_wb   = w_ok & wb_we_i  & (wb_waddr_i  == w_addr);

    assign w_fwd[2*k +: 2] = w_ex  ? 2'b01 :
                             w_mem ? 2'b10 :
                             w_wb  ? 2'b11 : 2'b00;
    assign w_lu_src[k]     = w_ex & ex_is_load_i;
  end

  assign w_load_use = |w_lu_src;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold      = 1'b0;
    w_flush     = 1'b0;
    if (jump_i) begin
      w_flush     = 1'b1;
      w_state_nxt = c_FL_NEXT;
      w_cnt_nxt   = c_FL_RELOAD;
    end else begin
      case (r_state)
        IDLE: begin
          if (div_busy_i) begin
            w_hold      = 1'b1;
            w_state_nxt = DIV_WAIT;
          end else if (w_load_use) begin
            w_hold      = 1'b1;
            w_state_nxt = c_LD_NEXT;
            w_cnt_nxt   = c_LD_RELOAD;
          end
        end
        LD_STALL: begin
          w_hold = 1'b1;
          if (r_cnt == 3'd1) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
        DIV_WAIT: begin
          // Release in the same cycle the divider drops; a pending load-use
          // is picked up by IDLE on the following cycle.
          if (div_busy_i) w_hold = 1'b1;
          else            w_state_nxt = IDLE;
        end
        FLUSH: begin
          w_flush = 1'b1;
          if (r_cnt == 3'd1) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A flush lets the PC load the jump target rather than freezing it.
  assign hold_pc_o      = ~rst & w_hold & ~w_flush;
  assign hold_if_id_o   = ~rst & w_hold;
  assign bubble_id_ex_o = ~rst & w_hold;
  assign flush_o        = ~rst & w_flush;
  assign busy_o         = ~rst & (r_state != IDLE);
  assign fwd_sel_o      = rst ? '0 : w_fwd;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios plus a randomized run checked against a
// cycle-count reference model of the hazard unit.
`default_nettype none

module tb_hazard_unit;

  localparam int W  = 5;
  localparam int NS = 2;
  localparam int LL = 3;
  localparam int FC = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS*W-1:0] id_raddr;
  logic [NS-1:0]   id_re;
  logic [W-1:0]    ex_waddr, mem_waddr, wb_waddr;
  logic            ex_we, ex_is_load, mem_we, wb_we, jump, div_busy;
  logic [2*NS-1:0] fwd_sel;
  logic            hold_pc, hold_if_id, bubble, flush, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_unit #(
    .REG_ADDR_W  (W),
    .NUM_SRC     (NS),
    .LOAD_LAT    (LL),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_raddr_i    (id_raddr),
    .id_re_i       (id_re),
    .ex_waddr_i    (ex_waddr),
    .ex_we_i       (ex_we),
    .ex_is_load_i  (ex_is_load),
    .mem_waddr_i   (mem_waddr),
    .mem_we_i      (mem_we),
    .wb_waddr_i    (wb_waddr),
    .wb_we_i       (wb_we),
    .jump_i        (jump),
    .div_busy_i    (div_busy),
    .fwd_sel_o     (fwd_sel),
    .hold_pc_o     (hold_pc),
    .hold_if_id_o  (hold_if_id),
    .bubble_id_ex_o(bubble),
    .flush_o       (flush),
    .busy_o        (busy)
  );

  task automatic clear_inputs();
    id_raddr = '0; id_re = '0;
    ex_waddr = '0; ex_we = 1'b0; ex_is_load = 1'b0;
    mem_waddr = '0; mem_we = 1'b0;
    wb_waddr = '0; wb_we = 1'b0;
    jump = 1'b0; div_busy = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    jump = 1'b1;
    ex_waddr = 5'd7; ex_we = 1'b1; ex_is_load = 1'b1;
    id_raddr = {5'd7, 5'd7}; id_re = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({fwd_sel, hold_pc, hold_if_id, bubble, flush, busy} !== 9'd0) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 000000000", i,
                 {fwd_sel, hold_pc, hold_if_id, bubble, flush, busy});
      end
      next_cycle();
    end
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    n_vec++;
    if ({hold_pc, hold_if_id, bubble, flush, busy} !== 5'd0) begin
      n_err++;
      $display("FAIL reset_release: got %b expected 00000",
               {hold_pc, hold_if_id, bubble, flush, busy});
    end
    next_cycle();
  endtask

  task automatic test_forward();
    logic [3:0] exp_sel [4];
    exp_sel[0] = 4'b0001; exp_sel[1] = 4'b0010;
    exp_sel[2] = 4'b0011; exp_sel[3] = 4'b0000;
    clear_inputs();
    id_raddr = {5'd9, 5'd5}; id_re = 2'b11;
    ex_waddr = 5'd5; mem_waddr = 5'd5; wb_waddr = 5'd5;
    ex_we = 1'b1; mem_we = 1'b1; wb_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) ex_we = 1'b0;
      if (i == 2) mem_we = 1'b0;
      if (i == 3) begin
        id_raddr = '0;
        ex_waddr = '0; mem_waddr = '0; wb_waddr = '0;
        ex_we = 1'b1; mem_we = 1'b1; wb_we = 1'b1; ex_is_load = 1'b1;
      end
      @(negedge clk);
      n_vec++;
      if (fwd_sel !== exp_sel[i] || hold_if_id !== 1'b0) begin
        n_err++;
        $display("FAIL forward_case%0d: got sel=%b hold=%b expected sel=%b hold=0",
                 i, fwd_sel, hold_if_id, exp_sel[i]);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    logic [3:0] got;
    logic [3:0] exp;
    clear_inputs();
    ex_waddr = 5'd7; ex_we = 1'b1; ex_is_load = 1'b1;
    id_raddr = {5'd7, 5'd3}; id_re = 2'b10;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      got = {hold_pc, hold_if_id, bubble, busy};
      exp = (c <= 3) ? {3'b111, (c >= 2)} : 4'b0000;
      n_vec++;
      if (got !== exp || (c == 1 && fwd_sel[3:2] !== 2'b01)) begin
        n_err++;
        $display("FAIL load_use cycle %0d: got hpc/hif/bub/busy=%b sel1=%b expected %b sel1=01",
                 c, got, fwd_sel[3:2], exp);
      end
      next_cycle();
      if (c == 1) clear_inputs();
    end
  endtask

  task automatic test_jump_in_stall();
    logic [4:0] got;
    logic [4:0] exp;
    clear_inputs();
    ex_waddr = 5'd7; ex_we = 1'b1; ex_is_load = 1'b1;
    id_raddr = {5'd7, 5'd0}; id_re = 2'b10;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        clear_inputs();
        jump = 1'b1;
      end
      if (c == 3) jump = 1'b0;
      @(negedge clk);
      got = {hold_pc, hold_if_id, bubble, flush, busy};
      case (c)
        1:       exp = 5'b11100;
        2:       exp = 5'b00011;
        3:       exp = 5'b00011;
        4:       exp = 5'b00011;
        default: exp = 5'b00000;
      endcase
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL jump_in_stall cycle %0d: got hpc/hif/bub/flush/busy=%b expected %b",
                 c, got, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_divider();
    clear_inputs();
    div_busy = 1'b1;
    ex_waddr = 5'd4; ex_we = 1'b1; ex_is_load = 1'b1;
    id_raddr = {5'd0, 5'd4}; id_re = 2'b01;
    for (int c = 1; c <= 7; c++) begin
      if (c == 6) div_busy = 1'b0;
      if (c == 7) clear_inputs();
      @(negedge clk);
      n_vec++;
      if ({hold_pc, hold_if_id, bubble} !== ((c <= 5) ? 3'b111 : 3'b000)) begin
        n_err++;
        $display("FAIL divider cycle %0d: got hpc/hif/bub=%b expected %b", c,
                 {hold_pc, hold_if_id, bubble}, (c <= 5) ? 3'b111 : 3'b000);
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    for (int s = 0; s < 2; s++) begin
      clear_inputs();
      for (int c = 1; c <= 5; c++) begin
        jump = (c == 1) || (s == 1 && c == 2);
        @(negedge clk);
        n_vec++;
        if ({flush, hold_pc} !== {(c <= 3 + s), 1'b0}) begin
          n_err++;
          $display("FAIL flush pulses=%0d cycle %0d: got flush/hpc=%b%b expected %b0",
                   s + 1, c, flush, hold_pc, (c <= 3 + s));
        end
        next_cycle();
      end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int         m_stall = 0;
    int         m_flush = 0;
    bit         m_div   = 1'b0;
    logic [3:0] e_sel;
    logic       e_hold, e_flush, e_busy, e_lu;
    logic [4:0] a;
    logic [1:0] sel;
    for (int n = 0; n < 3000; n++) begin
      rst        = (n == 0) || ($urandom_range(0, 59) == 0);
      id_raddr   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_re      = 2'($urandom);
      ex_waddr   = 5'($urandom_range(0, 3));
      mem_waddr  = 5'($urandom_range(0, 3));
      wb_waddr   = 5'($urandom_range(0, 3));
      ex_we      = 1'($urandom);
      mem_we     = 1'($urandom);
      wb_we      = 1'($urandom);
      ex_is_load = ($urandom_range(0, 2) == 0);
      jump       = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 5) == 0) div_busy = ~div_busy;

      e_sel = '0;
      e_lu  = 1'b0;
      for (int k = 0; k < NS; k++) begin
        a   = id_raddr[k*W +: W];
        sel = 2'd0;
        if (id_re[k] && a != 0) begin
          if (wb_we  && wb_waddr  == a) sel = 2'd3;
          if (mem_we && mem_waddr == a) sel = 2'd2;
          if (ex_we  && ex_waddr  == a) sel = 2'd1;
        end
        e_sel[2*k +: 2] = sel;
        if (sel == 2'd1 && ex_is_load) e_lu = 1'b1;
      end

      e_hold  = 1'b0;
      e_flush = 1'b0;
      e_busy  = !rst && (m_flush > 0 || m_div || m_stall > 0);
      if (rst) begin
        e_sel = '0;
        m_stall = 0; m_flush = 0; m_div = 1'b0;
      end else if (jump) begin
        e_flush = 1'b1;
        m_flush = FC - 1; m_stall = 0; m_div = 1'b0;
      end else if (m_flush > 0) begin
        e_flush = 1'b1;
        m_flush--;
      end else if (m_div) begin
        if (div_busy) e_hold = 1'b1;
        else          m_div = 1'b0;
      end else if (m_stall > 0) begin
        e_hold = 1'b1;
        m_stall--;
      end else if (div_busy) begin
        e_hold = 1'b1;
        m_div  = 1'b1;
      end else if (e_lu) begin
        e_hold  = 1'b1;
        m_stall = LL - 1;
      end

      @(negedge clk);
      n_vec++;
      if ({fwd_sel, hold_pc, hold_if_id, bubble, flush, busy} !==
          {e_sel, e_hold & ~e_flush, e_hold, e_hold, e_flush, e_busy}) begin
        n_err++;
        $display("FAIL random vec %0d: got sel/hpc/hif/bub/flush/busy=%b expected %b",
                 n, {fwd_sel, hold_pc, hold_if_id, bubble, flush, busy},
                 {e_sel, e_hold & ~e_flush, e_hold, e_hold, e_flush, e_busy});
      end
      next_cycle();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_jump_in_stall();
    test_divider();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised pipeline hazard unit; successor to the two-operand EX-only forwarding detector.
- Sits beside the ID stage and generates forwarding selects for NUM_SRC read operands from the EX, MEM and WB producers.
- Handles load-use interlock, multi-cycle divider hold and control-transfer flush through an internal FSM with a cycle counter.
- Register x0 never forwards and never stalls.

Parameters:
- REG_ADDR_W, 5, register address width.
- NUM_SRC, 2, number of ID-stage read operands checked.
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..7).
- FLUSH_CYCLES, 1, cycles flush_o is held per jump (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- id_raddr_i  in  NUM_SRC*REG_ADDR_W  ID read addresses; operand k occupies bits [k*REG_ADDR_W +: REG_ADDR_W].
- id_re_i  in  NUM_SRC  per-operand read enable.
- ex_waddr_i  in  REG_ADDR_W  EX destination register.
- ex_we_i  in  1  EX writes a register.
- ex_is_load_i  in  1  EX holds a load.
- mem_waddr_i  in  REG_ADDR_W  MEM destination register.
- mem_we_i  in  1  MEM writes a register.
- wb_waddr_i  in  REG_ADDR_W  WB destination register.
- wb_we_i  in  1  WB writes a register.
- jump_i  in  1  taken branch/jump resolved in EX.
- div_busy_i  in  1  divider busy.
- fwd_sel_o  out  2*NUM_SRC  per-operand select: 00 regfile, 01 EX, 10 MEM, 11 WB.
- hold_pc_o  out  1  freeze PC.
- hold_if_id_o  out  1  freeze IF/ID register.
- bubble_id_ex_o  out  1  load NOP into ID/EX.
- flush_o  out  1  squash IF/ID and ID/EX.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset:
  - All state is updated on the rising edge of clk.
  - rst=1 forces state IDLE and counter 0, including when asserted mid-stall or mid-flush.
  - While rst=1 all outputs are 0.
- Match rule: operand k matches stage S when id_re_i[k]=1, S_we=1, S_waddr equals the operand address, and the operand address is not 0.
- Forwarding (combinational, every cycle):
  - Select priority is EX > MEM > WB > regfile, chosen independently per operand.
  - An EX match while ex_is_load_i=1 still reports 01, but it also raises load-use.
- load_use = any operand matches EX while ex_is_load_i=1.
- FSM states and counter:
  - States: IDLE, LD_STALL, DIV_WAIT, FLUSH.
  - A 3-bit counter cnt is used in LD_STALL and FLUSH.
- Event priority in every state: rst > jump_i > div_busy_i > load_use.
- IDLE:
  - jump_i: flush_o=1 this cycle. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - else div_busy_i: hold_pc_o=hold_if_id_o=bubble_id_ex_o=1 this cycle; go to DIV_WAIT.
  - else load_use: hold_pc_o=hold_if_id_o=bubble_id_ex_o=1 this cycle. If LOAD_LAT>1, go to LD_STALL with cnt=LOAD_LAT-1.
- LD_STALL:
  - hold_pc_o, hold_if_id_o and bubble_id_ex_o are 1.
  - cnt decrements each cycle; on the cycle cnt==1, return to IDLE.
  - jump_i has priority: it cancels the stall and enters FLUSH per the IDLE rule.
- DIV_WAIT:
  - hold and bubble outputs stay 1 while div_busy_i=1.
  - First cycle with div_busy_i=0: outputs go to 0 that same cycle; next state is IDLE.
  - jump_i has priority as in IDLE.
- FLUSH:
  - flush_o=1; cnt decrements; on the cycle cnt==1, return to IDLE.
  - A new jump_i reloads cnt=FLUSH_CYCLES-1.
  - hold and bubble outputs are 0.
- Output combination rules:
  - flush_o=1 forces hold_pc_o=0 so the PC takes the jump target.
  - bubble_id_ex_o and flush_o may both be 1.
- Total stall length is exactly LOAD_LAT cycles per load-use event, and exactly FLUSH_CYCLES flush cycles per jump.
- busy_o = (state != IDLE).

Test Plan:
- Reset: rst=1 for 3 cycles with jump_i=1 and load_use present -> all outputs 0; after release, state IDLE and busy_o=0.
- Forward priority: operand0=x5; EX, MEM and WB all write x5 (no load) -> fwd_sel[1:0]=01. Drop ex_we -> 10; drop mem_we -> 11. An operand of x0 with all stages writing x0 -> 00.
- Load-use, LOAD_LAT=3: EX load to x7, operand1=x7 -> hold_pc_o/hold_if_id_o/bubble_id_ex_o=1 for exactly 3 cycles, busy_o=1 for cycles 2-3, IDLE on cycle 4.
- Jump during stall, LOAD_LAT=3: assert jump_i in stall cycle 2 -> flush_o=1 that cycle, hold_pc_o=0, the stall is abandoned, and no further bubbles follow.
- Divider: div_busy_i high for 5 cycles -> hold asserted for 5 cycles and deasserted in the cycle div_busy_i falls; load_use present at the same time does not extend the hold.
- Flush, FLUSH_CYCLES=3: single jump_i pulse -> flush_o=1 for 3 cycles. A second pulse in cycle 2 -> flush_o stays 1 through cycle 4.
